// File: rtl/ntru_pkg.sv
// ntru_pkg: shared ring defaults, multiplier FSM states and mode encoding
package ntru_pkg;
  localparam int N_DEF = 701;
  localparam int LOG_Q_DEF = 13;
  localparam logic MODE_RQ = 1'b0;
  localparam logic MODE_SQ = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, FOLD, DONE} state_t;
endpackage

// File: rtl/poly_mac_lane.sv
// poly_mac_lane: scalar coefficient times an N-coefficient vector, mod 2^LOG_Q
module poly_mac_lane
  import ntru_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int LOG_Q = LOG_Q_DEF
) (
  input  logic [LOG_Q-1:0]   a,
  input  logic [N*LOG_Q-1:0] v,
  output logic [N*LOG_Q-1:0] p
);
  genvar i;
  for (i = 0; i < N; i++) begin : g_coef
    assign p[i*LOG_Q +: LOG_Q] = a * v[i*LOG_Q +: LOG_Q];
  end
endmodule

// File: rtl/poly_mul_sq_par.sv
// poly_mul_sq_par: P-lane streaming product h*c in Rq (x^N-1) or Sq (Phi_N)
module poly_mul_sq_par
  import ntru_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int LOG_Q = LOG_Q_DEF,
  parameter int P = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [N*LOG_Q-1:0] h,
  input  logic               c_valid,
  output logic               c_ready,
  input  logic [P*LOG_Q-1:0] c,
  output logic               busy,
  output logic               done,
  output logic [N*LOG_Q-1:0] e
);
  localparam int NB = (N + P - 1) / P;
  localparam int CW = $clog2(NB + 1);
  state_t state, state_n;
  logic mode_reg;
  logic [CW-1:0] cnt;
  logic [N*LOG_Q-1:0] h_reg, h_next, e_sum, e_fold;
  logic [N*LOG_Q-1:0] rot_h [P];
  logic [N*LOG_Q-1:0] prod [P];
  logic [LOG_Q-1:0] lane_c [P];
  logic last;
  assign last = cnt == CW'(NB - 1);
  assign c_ready = state == RUN;
  assign busy = state != IDLE;
  assign done = state == DONE;
  genvar i, k;
  for (k = 0; k < P; k++) begin : g_lane
    for (i = 0; i < N; i++) begin : g_rot
      assign rot_h[k][i*LOG_Q +: LOG_Q] = h_reg[((i + N - k) % N)*LOG_Q +: LOG_Q];
    end
    // lanes past the last coefficient of c are masked regardless of what they carry
    assign lane_c[k] = (int'(cnt) * P + k < N) ? c[k*LOG_Q +: LOG_Q] : '0;
    poly_mac_lane #(.N(N), .LOG_Q(LOG_Q)) u_lane (
      .a(lane_c[k]),
      .v(rot_h[k]),
      .p(prod[k])
    );
  end
  for (i = 0; i < N; i++) begin : g_hnext
    assign h_next[i*LOG_Q +: LOG_Q] = h_reg[((i + N - (P % N)) % N)*LOG_Q +: LOG_Q];
  end
  always_comb begin
    e_sum = e;
    for (int m = 0; m < P; m++)
      for (int j = 0; j < N; j++)
        e_sum[j*LOG_Q +: LOG_Q] = e_sum[j*LOG_Q +: LOG_Q] + prod[m][j*LOG_Q +: LOG_Q];
  end
  // reduction by Phi_N: subtracting the top coefficient from every term zeroes it
  always_comb begin
    e_fold = e;
    for (int j = 0; j < N; j++)
      e_fold[j*LOG_Q +: LOG_Q] = e[j*LOG_Q +: LOG_Q] - e[(N-1)*LOG_Q +: LOG_Q];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? RUN : IDLE;
      RUN: state_n = (c_valid && last) ? FOLD : RUN;
      FOLD: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mode_reg <= MODE_RQ;
      cnt <= '0;
      h_reg <= '0;
      e <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        h_reg <= h;
        mode_reg <= mode;
        e <= '0;
        cnt <= '0;
      end
      if (state == RUN && c_valid) begin
        e <= e_sum;
        h_reg <= h_next;
        cnt <= cnt + 1'b1;
      end
      if (state == FOLD && mode_reg == MODE_SQ) e <= e_fold;
    end
  end
endmodule

// File: doc/poly_mul_sq_par.md
POLY_MUL_SQ_PAR -- requirements
Module: poly_mul_sq_par

Interface
REQ-001 SHALL have parameter N, default 701: ring degree (number of coefficients).
REQ-002 SHALL have parameter LOG_Q, default 13: coefficient width; q = 2^LOG_Q.
REQ-003 SHALL have parameter P, default 1: coefficients of c accepted per beat; 1 <= P <= N.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: begin a multiplication; sampled only in IDLE.
REQ-007 SHALL have port mode, input, 1: 0 = product in Rq, mod (x^N - 1); 1 = product in Sq, mod (q, Phi_N). Captured on start.
REQ-008 SHALL have port h, input, N*LOG_Q: multiplicand. Coefficient k is at bits [k*LOG_Q +: LOG_Q]. Captured on start.
REQ-009 SHALL have port c_valid, input, 1: the c beat is valid.
REQ-010 SHALL have port c_ready, output, 1: high exactly in state RUN.
REQ-011 SHALL have port c, input, P*LOG_Q: beat of c coefficients. Lane k carries coefficient b*P+k for beat b.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when e is final.
REQ-014 SHALL have port e, output, N*LOG_Q: product accumulator, using the same coefficient layout as h.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FOLD, DONE.
REQ-016 In IDLE, start=1 SHALL load h_reg<=h, mode_reg<=mode, e<=0 and beat counter<=0, then move to RUN.
REQ-017 start SHALL be ignored in every state except IDLE.
REQ-018 In RUN, a beat SHALL be accepted only on a cycle with c_valid=1; when c_valid=0 all state holds.
REQ-019 Each accepted beat SHALL perform e <= e + sum over k<P of c_k * rot(h_reg,k).
REQ-020 Each accepted beat SHALL also perform h_reg <= rot(h_reg,P).
REQ-021 rot(v,s) SHALL be the cyclic up-shift by s coefficients: new index (i+s) mod N.
REQ-022 Lanes with b*P+k >= N SHALL contribute zero, whatever value they carry.
REQ-023 All products and sums SHALL be truncated to LOG_Q bits, i.e. reduced mod 2^LOG_Q; c and h are unsigned.
REQ-024 After ceil(N/P) accepted beats the FSM SHALL go to FOLD; it SHALL accept no further beats.
REQ-025 FOLD SHALL last one cycle.
REQ-026 In FOLD with mode_reg=1, e_i <= e_i - e_{N-1} mod q for all i, giving e_{N-1}=0.
REQ-027 In FOLD with mode_reg=0, e SHALL be unchanged.
REQ-028 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-029 e SHALL hold its value from DONE until the next accepted start.
REQ-030 Latency from the last accepted beat to done SHALL be exactly 2 cycles.
REQ-031 With c_valid held high, start-to-done SHALL be ceil(N/P)+2 cycles.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, c_ready=0, busy=0, done=0, e=0, h_reg=0 and beat counter=0, regardless of clock.
REQ-033 Reset during RUN or FOLD SHALL abandon the operation; no done pulse SHALL be issued.
REQ-034 The first start after rst deasserts SHALL be honoured normally.

Structure
REQ-035 A shared package ntru_pkg SHALL hold the default N and LOG_Q, the state enum, and the mode encoding (MODE_RQ=0, MODE_SQ=1).
REQ-036 One sub-module poly_mac_lane SHALL compute the contribution of one lane: scalar coefficient times an N-coefficient vector, mod 2^LOG_Q.
REQ-037 The top SHALL instantiate P copies of poly_mac_lane, each fed rot(h_reg,k), and sum their outputs with e.

Verification
REQ-038 N=5, LOG_Q=4, P=2, mode=0, h=x, c=[1,2,3,4,5], c_valid high -> done at cycle 5 after start; e=[5,1,2,3,4].
REQ-039 Same as REQ-038 with mode=1 -> e=[1,13,14,15,0].
REQ-040 N=5, LOG_Q=4, P=2, h and c all coefficients 15 -> mode 0: every e_i=5; mode 1: every e_i=0.
REQ-041 N=5, P=2, beat 3 lane 1 driven to 9 -> result identical to REQ-038.
REQ-041 also: c_valid low 3 cycles after beat 1 -> c_ready stays high, result unchanged, done 3 cycles later.
REQ-042 N=701, LOG_Q=13, P=1, h=1 (h0=1), random c -> mode 0: e equals c; start pulsed during RUN is ignored.
REQ-043 rst asserted mid-RUN -> outputs zero the same cycle, no done pulse; a following start completes correctly.
